// File: rtl/rename_serialize_sequencer_if.sv
// Handshake bundle between the rename pipeline/controller and the serialize sequencer.
// The slave modport is the sequencer's view; master is the surrounding rename logic.
interface rename_serialize_sequencer_if #(
   parameter int CNT_W = 16
) ();
   logic             stall_i;
   logic             clear_i;
   logic             op_valid_i;
   logic             op_serialized_i;
   logic             op_fence_i;
   logic             op_fencei_i;
   logic             al_empty_i;
   logic             sq_empty_i;
   logic             commit_serialized_i;
   logic             ic_flush_ack_i;
   logic             serialize_o;
   logic             ic_flush_req_o;
   logic             dispatch_o;
   logic             busy_o;
   logic [CNT_W-1:0] drain_cycles_o;
   logic             watchdog_err_o;

   modport master (
      output stall_i, clear_i, op_valid_i, op_serialized_i, op_fence_i, op_fencei_i,
             al_empty_i, sq_empty_i, commit_serialized_i, ic_flush_ack_i,
      input  serialize_o, ic_flush_req_o, dispatch_o, busy_o, drain_cycles_o, watchdog_err_o
   );

   modport slave (
      input  stall_i, clear_i, op_valid_i, op_serialized_i, op_fence_i, op_fencei_i,
             al_empty_i, sq_empty_i, commit_serialized_i, ic_flush_ack_i,
      output serialize_o, ic_flush_req_o, dispatch_o, busy_o, drain_cycles_o, watchdog_err_o
   );
endinterface

// File: rtl/rename_serialize_sequencer.sv
// Sequences serialized ops at rename lane 0: drain older work, flush the I-cache for FENCE.I,
// release one dispatch, then block until commit. Optional watchdog: RSD_SERIALIZE_WATCHDOG_EN.
module rename_serialize_sequencer #(
   parameter int CNT_W          = 16,
   parameter int WATCHDOG_LIMIT = 4096
) (
   input logic                         clk,
   input logic                         rst,
   rename_serialize_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      FLUSH_IC = 3'd2,
      IC_ABORT = 3'd3,
      DISPATCH = 3'd4,
      WAIT_OWN = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_next_s;
   state_t           case_next_s;
   logic             need_sq_r;
   logic             fencei_r;
   logic             seen_commit_r;
   logic [CNT_W-1:0] drain_cnt_r;
   logic             need_sq_s;
   logic             fencei_s;
   logic             drained_s;
   logic             state_en_s;
   logic             leave_idle_s;
   logic             commit_done_s;
   logic             serialize_s;
   logic             ic_req_s;
   logic             dispatch_s;
   logic             cnt_inc_s;

   assign need_sq_s     = (state_r == IDLE) ? (bus.op_fence_i | bus.op_fencei_i) : need_sq_r;
   assign fencei_s      = (state_r == IDLE) ? bus.op_fencei_i : fencei_r;
   assign drained_s     = bus.al_empty_i & (~need_sq_s | bus.sq_empty_i);
   assign state_en_s    = ~bus.stall_i | bus.clear_i | (state_r == FLUSH_IC) | (state_r == IC_ABORT);
   assign commit_done_s = (seen_commit_r | bus.commit_serialized_i) & bus.al_empty_i & bus.sq_empty_i;
   assign leave_idle_s  = (state_r == IDLE) & state_en_s &
                          ((state_next_s == DRAIN) | (state_next_s == FLUSH_IC));

   // Next state and per-state outputs; a flush never withdraws an outstanding I-cache request
   always_comb begin
      case_next_s = state_r;
      serialize_s = 1'b0;
      ic_req_s    = 1'b0;
      dispatch_s  = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.op_valid_i & bus.op_serialized_i) begin
               if (drained_s & ~fencei_s) begin
                  dispatch_s  = ~bus.stall_i & ~bus.clear_i;
                  case_next_s = WAIT_OWN;
               end else begin
                  serialize_s = 1'b1;
                  case_next_s = drained_s ? FLUSH_IC : DRAIN;
               end
            end else begin
               case_next_s = IDLE;
            end
         end
         DRAIN: begin
            serialize_s = 1'b1;
            cnt_inc_s   = 1'b1;
            if (drained_s) begin
               case_next_s = fencei_s ? FLUSH_IC : DISPATCH;
            end else begin
               case_next_s = DRAIN;
            end
         end
         FLUSH_IC: begin
            serialize_s = 1'b1;
            ic_req_s    = 1'b1;
            cnt_inc_s   = 1'b1;
            case_next_s = bus.ic_flush_ack_i ? DISPATCH : FLUSH_IC;
         end
         IC_ABORT: begin
            serialize_s = 1'b1;
            ic_req_s    = 1'b1;
            case_next_s = bus.ic_flush_ack_i ? IDLE : IC_ABORT;
         end
         DISPATCH: begin
            dispatch_s  = ~bus.stall_i & ~bus.clear_i;
            case_next_s = WAIT_OWN;
         end
         WAIT_OWN: begin
            serialize_s = 1'b1;
            case_next_s = commit_done_s ? IDLE : WAIT_OWN;
         end
         default: begin
            case_next_s = IDLE;
         end
      endcase
      if (bus.clear_i) begin
         if (((state_r == FLUSH_IC) || (state_r == IC_ABORT)) && !bus.ic_flush_ack_i) begin
            state_next_s = IC_ABORT;
         end else begin
            state_next_s = IDLE;
         end
      end else begin
         state_next_s = case_next_s;
      end
   end

   // FSM state register, frozen by stall except while waiting on the I-cache
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else if (state_en_s) begin
         state_r <= state_next_s;
      end else begin
         state_r <= state_r;
      end
   end

   // Op attributes sampled while IDLE so later states ignore the lane-0 inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         need_sq_r <= 1'b0;
         fencei_r  <= 1'b0;
      end else if (state_r == IDLE) begin
         need_sq_r <= need_sq_s;
         fencei_r  <= fencei_s;
      end else begin
         need_sq_r <= need_sq_r;
         fencei_r  <= fencei_r;
      end
   end

   // Commit can precede the drain of older work, so remember it until WAIT_OWN exits
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_commit_r <= 1'b0;
      end else if (state_r != WAIT_OWN) begin
         seen_commit_r <= 1'b0;
      end else if (state_en_s && (state_next_s == IDLE)) begin
         seen_commit_r <= 1'b0;
      end else if (bus.commit_serialized_i) begin
         seen_commit_r <= 1'b1;
      end else begin
         seen_commit_r <= seen_commit_r;
      end
   end

   // Saturating count of DRAIN/FLUSH_IC cycles, restarted whenever an op leaves IDLE that way
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt_r <= '0;
      end else if (leave_idle_s) begin
         drain_cnt_r <= '0;
      end else if (cnt_inc_s && (drain_cnt_r != CNT_MAX)) begin
         drain_cnt_r <= drain_cnt_r + CNT_ONE;
      end else begin
         drain_cnt_r <= drain_cnt_r;
      end
   end

   assign bus.serialize_o    = serialize_s;
   assign bus.ic_flush_req_o = ic_req_s;
   assign bus.dispatch_o     = dispatch_s;
   assign bus.busy_o         = (state_r != IDLE);
   assign bus.drain_cycles_o = drain_cnt_r;

`ifdef RSD_SERIALIZE_WATCHDOG_EN
   localparam int              WD_W   = $clog2(WATCHDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(WATCHDOG_LIMIT);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            wd_err_r;

   // Consecutive busy cycles; the error latches on the cycle the count reaches the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= '0;
         wd_err_r <= 1'b0;
      end else if (state_r == IDLE) begin
         wd_cnt_r <= '0;
         wd_err_r <= wd_err_r;
      end else begin
         wd_cnt_r <= (wd_cnt_r != WD_LIM) ? (wd_cnt_r + WD_ONE) : wd_cnt_r;
         wd_err_r <= wd_err_r | (wd_cnt_r == (WD_LIM - WD_ONE));
      end
   end

   assign bus.watchdog_err_o = wd_err_r;
`else
   assign bus.watchdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rename_serialize_sequencer.sv
// Randomized self-checking bench for rename_serialize_sequencer: each serialized op is expanded
// from its scenario (drain lengths, ack delay, stalls, commit delay) into per-cycle expectations.
module tb_rename_serialize_sequencer;
   localparam int CW   = 3;
   localparam int WDL  = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   int   chk_cnt   = 0;
   int   err_cnt   = 0;
   int   model_cnt = 0;
   int   wd_run    = 0;
   int   model_wd  = 0;

   rename_serialize_sequencer_if #(.CNT_W(CW)) bus ();

   rename_serialize_sequencer #(.CNT_W(CW), .WATCHDOG_LIMIT(WDL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout sim time exceeded, got running exp finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.stall_i             = 1'b0;
      bus.clear_i             = 1'b0;
      bus.op_valid_i          = 1'b0;
      bus.op_serialized_i     = 1'b0;
      bus.op_fence_i          = 1'b0;
      bus.op_fencei_i         = 1'b0;
      bus.al_empty_i          = 1'b1;
      bus.sq_empty_i          = 1'b1;
      bus.commit_serialized_i = 1'b0;
      bus.ic_flush_ack_i      = 1'b0;
   endtask

   // Checks one cycle of outputs at the falling edge, then moves just past the next rising edge.
   task automatic expect_outs(input string tag, input logic ser, input logic req,
                              input logic disp, input logic busy, input logic chk_drain);
      @(negedge clk);
      check({tag, ".ser"},  32'(bus.serialize_o),    32'(ser));
      check({tag, ".req"},  32'(bus.ic_flush_req_o), 32'(req));
      check({tag, ".disp"}, 32'(bus.dispatch_o),     32'(disp));
      check({tag, ".busy"}, 32'(bus.busy_o),         32'(busy));
      if (chk_drain) begin
         check({tag, ".cnt"}, 32'(bus.drain_cycles_o), 32'(model_cnt));
      end
`ifdef RSD_SERIALIZE_WATCHDOG_EN
      check({tag, ".wd"}, 32'(bus.watchdog_err_o), 32'(model_wd));
      if (busy) begin
         wd_run++;
         if (wd_run >= WDL) model_wd = 1;
      end else begin
         wd_run = 0;
      end
`else
      check({tag, ".wd"}, 32'(bus.watchdog_err_o), 32'(0));
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      model_cnt = 0;
      wd_run    = 0;
      model_wd  = 0;
   endtask

   // kind: 0 CSR, 1 FENCE, 2 FENCE.I; a: cycles AL busy; s: further cycles SQ busy;
   // w: ack on w-th flush cycle; st: stall cycles at dispatch; c: cycles before commit.
   task automatic run_op(input int kind, input int a, input int s, input int w,
                         input int st, input int c);
      bit fi;
      bit nsq;
      bit zero;
      int d;
      int tot;
      fi   = (kind == 2);
      nsq  = (kind != 0);
      d    = nsq ? (a + s) : a;
      zero = (d == 0) && !fi;
      bus.op_valid_i      = 1'b1;
      bus.op_serialized_i = 1'b1;
      bus.op_fence_i      = (kind == 1);
      bus.op_fencei_i     = fi;
      bus.al_empty_i      = (a == 0);
      bus.sq_empty_i      = (a + s == 0);
      if (zero) begin
         expect_outs("zero", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end else begin
         expect_outs("enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         for (int k = 1; k <= d; k++) begin
            bus.al_empty_i = (k >= a);
            bus.sq_empty_i = (k >= a + s);
            expect_outs("drain", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         end
         bus.al_empty_i = 1'b1;
         bus.sq_empty_i = 1'b1;
         if (fi) begin
            for (int j = 1; j <= w; j++) begin
               bus.ic_flush_ack_i = (j == w);
               expect_outs("flush", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            bus.ic_flush_ack_i = 1'b0;
         end
         tot = d + (fi ? w : 0);
         model_cnt = (tot > CMAX) ? CMAX : tot;
         for (int j = 0; j <= st; j++) begin
            bus.stall_i = (j < st);
            expect_outs("dispatch", 1'b0, 1'b0, (j == st), 1'b1, 1'b1);
         end
         bus.stall_i = 1'b0;
      end
      idle_inputs();
      for (int j = 0; j <= c; j++) begin
         bus.commit_serialized_i = (j == c);
         bus.op_valid_i          = 1'($urandom_range(0, 1));
         bus.op_serialized_i     = 1'($urandom_range(0, 1));
         bus.op_fencei_i         = 1'($urandom_range(0, 1));
         expect_outs("wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      idle_inputs();
      expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      expect_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef RSD_SERIALIZE_WATCHDOG_EN
      // FENCE whose older ops never drain: error after WDL busy cycles, sticky past IDLE
      bus.op_valid_i      = 1'b1;
      bus.op_serialized_i = 1'b1;
      bus.op_fence_i      = 1'b1;
      bus.al_empty_i      = 1'b0;
      expect_outs("wd_enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < WDL + 2; k++) expect_outs("wd_drain", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_inputs();
      bus.clear_i = 1'b1;
      expect_outs("wd_clear", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.clear_i = 1'b0;
      expect_outs("wd_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("wd_sticky", 32'(bus.watchdog_err_o), 32'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      expect_outs("wd_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      run_op(0, 0, 0, 1, 0, 3);   // CSR with empty AL: zero-cycle dispatch
      run_op(1, 5, 2, 1, 0, 0);   // FENCE: 5 AL + 2 SQ drain cycles, count 7
      run_op(2, 0, 0, 4, 0, 1);   // FENCE.I drained: request for 4 cycles
      run_op(0, 2, 0, 1, 3, 1);   // stall held 3 cycles at dispatch
      run_op(2, 4, 3, 4, 1, 2);   // counter saturates

      // clear during FLUSH_IC: request stays up until ack, no dispatch
      bus.op_valid_i      = 1'b1;
      bus.op_serialized_i = 1'b1;
      bus.op_fencei_i     = 1'b1;
      expect_outs("abort_enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      bus.clear_i = 1'b1;
      expect_outs("abort_clr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.clear_i = 1'b0;
      expect_outs("abort_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.ic_flush_ack_i = 1'b1;
      expect_outs("abort_ack", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.ic_flush_ack_i = 1'b0;
      model_cnt = 1;
      expect_outs("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_outs("abort_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // reset while waiting for commit
      bus.op_valid_i      = 1'b1;
      bus.op_serialized_i = 1'b1;
      expect_outs("rw_disp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_inputs();
      rst = 1'b1;
      expect_outs("rw_wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      model_reset();
      expect_outs("rw_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule
